// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a small transmit FIFO.
// Frame format is 8N1 by default. Defining UART_TX_PARITY_EN adds an even
// parity bit after data bit 7, giving 8E1 (11 bit times per frame).
// FIFO storage is a plain array with a registered read, so it maps to RAM.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic [2:0]    state_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_serial_reg;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg;
`endif

    logic fifo_empty;
    logic push;
    logic pop;
    logic bit_end;

    // Handshake and pop decisions. A pop happens either from IDLE or at the
    // very end of a stop bit, so back-to-back frames have no idle gap.
    always_comb begin
        fifo_empty = (count_reg == '0);
        tx_ready   = (count_reg < DEPTH_C);
        push       = tx_valid && tx_ready && !rst;
        bit_end    = (baud_cnt_reg == BAUD_LAST);
        pop        = !fifo_empty &&
                     ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
        tx_busy    = (state_reg != IDLE) || !fifo_empty;
    end

    assign tx_serial = tx_serial_reg;

    // FIFO storage write port; no reset so it can live in RAM.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Frame sequencer: shifts the popped byte out LSB first, one bit per
    // CLKS_PER_BIT cycles, with the line value registered at each boundary.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            tx_serial_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    if (pop) begin
                        shift_reg     <= fifo_mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
                        parity_reg    <= ^fifo_mem[rd_ptr_reg];
`endif
                        tx_serial_reg <= 1'b0;
                        state_reg     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt_reg  <= '0;
                        bit_idx_reg   <= '0;
                        tx_serial_reg <= shift_reg[0];
                        shift_reg     <= {1'b0, shift_reg[7:1]};
                        state_reg     <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_serial_reg <= parity_reg;
                            state_reg     <= PARITY;
`else
                            tx_serial_reg <= 1'b1;
                            state_reg     <= STOP;
`endif
                        end else begin
                            bit_idx_reg   <= bit_idx_reg + 1'b1;
                            tx_serial_reg <= shift_reg[0];
                            shift_reg     <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt_reg  <= '0;
                        tx_serial_reg <= 1'b1;
                        state_reg     <= STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (pop) begin
                            shift_reg     <= fifo_mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
                            parity_reg    <= ^fifo_mem[rd_ptr_reg];
`endif
                            tx_serial_reg <= 1'b0;
                            state_reg     <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    baud_cnt_reg  <= '0;
                    tx_serial_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Two instances share one clock:
// dut_a uses the default 868 cycles/bit with a 4-deep FIFO, dut_b uses
// 4 cycles/bit with a 2-deep FIFO. A line monitor per instance decodes
// every frame and checks it cycle by cycle against a byte scoreboard.
module tb_uart_tx;

    localparam int CPB_A   = 868;
    localparam int DEPTH_A = 4;
    localparam int CPB_B   = 4;
    localparam int DEPTH_B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic       a_serial, b_serial;
    logic       a_busy, b_busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int starts_a[$];
    int starts_b[$];
    int done_a = 0;
    int done_b = 0;
    int aborts_a = 0;

    uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
        .sys_clk  (clk),
        .rst      (rst),
        .tx_data  (a_data),
        .tx_valid (a_valid),
        .tx_ready (a_ready),
        .tx_serial(a_serial),
        .tx_busy  (a_busy)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH_B)) dut_b (
        .sys_clk  (clk),
        .rst      (rst),
        .tx_data  (b_data),
        .tx_valid (b_valid),
        .tx_ready (b_ready),
        .tx_serial(b_serial),
        .tx_busy  (b_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line value for each bit time of a frame carrying d.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Receiver model: detects a start bit, checks every cycle of the frame
    // against the scoreboard head, recovers the byte from mid-bit samples.
    task automatic run_monitor(input int which);
        int          cpb;
        int          start;
        int          bad;
        bit          aborted;
        bit          have;
        logic        s;
        logic [7:0]  exp_byte;
        logic [7:0]  rx_byte;
        logic [10:0] fb;
        cpb = (which == 0) ? CPB_A : CPB_B;
        forever begin
            @(negedge clk);
            s = (which == 0) ? a_serial : b_serial;
            if (!rst && s === 1'b0) begin
                start = cyc;
                if (which == 0) starts_a.push_back(start);
                else            starts_b.push_back(start);
                have = (which == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
                check((which == 0) ? "a_frame_expected" : "b_frame_expected", int'(have), 1);
                exp_byte = 8'h00;
                if (have) exp_byte = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
                fb      = frame_bits(exp_byte);
                bad     = 0;
                aborted = 1'b0;
                rx_byte = 8'h00;
                for (int off = 0; off < FRAME * cpb; off++) begin
                    if (off > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    s = (which == 0) ? a_serial : b_serial;
                    if (s !== fb[off / cpb]) bad++;
                    if ((off % cpb) == (cpb / 2) && (off / cpb) >= 1 && (off / cpb) <= 8)
                        rx_byte[(off / cpb) - 1] = s;
                end
                if (aborted) begin
                    if (which == 0) aborts_a++;
                end else begin
                    $display("[TB] dut_%s frame at cycle %0d byte 0x%02h (expected 0x%02h)",
                             (which == 0) ? "a" : "b", start, rx_byte, exp_byte);
                    check((which == 0) ? "a_rx_byte" : "b_rx_byte", int'(rx_byte), int'(exp_byte));
                    check((which == 0) ? "a_frame_shape" : "b_frame_shape", bad, 0);
                    if (which == 0) done_a++;
                    else            done_b++;
                end
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);

    initial begin
        #(990_000);
        $display("FAIL watchdog cycle=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    logic [7:0] seq5 [5];
    int c0;
    int base_done;
    int bad;
    int waited;
    logic [7:0] rb;

    initial begin
        seq5[0] = 8'h93; seq5[1] = 8'h00; seq5[2] = 8'h10; seq5[3] = 8'h00; seq5[4] = 8'hAA;

        // Reset with tx_valid high: the byte must not be taken.
        rst = 1'b1; a_data = 8'hFF; a_valid = 1'b1; b_data = 8'h00; b_valid = 1'b0;
        repeat (3) step();
        check("rst_a_serial", int'(a_serial), 1);
        check("rst_a_ready",  int'(a_ready),  1);
        check("rst_a_busy",   int'(a_busy),   0);
        check("rst_b_serial", int'(b_serial), 1);
        rst = 1'b0; a_valid = 1'b0;
        step();
        check("rst_ignores_valid", int'(a_busy), 0);

        // Single 0x93 frame: start bit one edge after the write, idle after 10 bits.
        a_data = 8'h93; a_valid = 1'b1; exp_a.push_back(8'h93);
        step();
        c0 = cyc; a_valid = 1'b0; a_data = 8'h5A;
        step();
        check("single_busy", int'(a_busy), 1);
        check("single_start_low", int'(a_serial), 0);
        wait_until(c0 + FRAME * CPB_A);
        check("single_busy_last", int'(a_busy), 1);
        step();
        check("single_busy_done", int'(a_busy), 0);
        check("single_frames", done_a, 1);
        check("single_start_cycle", starts_a[0], c0 + 1);

        // tx_valid held high for five bytes: FIFO fills, then frames run back to back.
        starts_a.delete();
        base_done = done_a;
        for (int i = 0; i < 5; i++) begin
            a_data = seq5[i]; a_valid = 1'b1;
            check("fill_ready", int'(a_ready), 1);
            exp_a.push_back(seq5[i]);
            step();
            if (i == 0) c0 = cyc;
        end
        a_valid = 1'b0;
        check("full_ready", int'(a_ready), 0);
        wait_until(c0 + FRAME * CPB_A);
        check("full_ready_before_pop", int'(a_ready), 0);
        step();
        check("ready_after_pop", int'(a_ready), 1);
        wait_until(c0 + 1 + 5 * FRAME * CPB_A);
        check("b2b_busy_done", int'(a_busy), 0);
        check("b2b_frames", done_a - base_done, 5);
        check("b2b_first_start", starts_a.size() > 0 ? starts_a[0] : -1, c0 + 1);
        for (int k = 1; k < 5; k++)
            check("b2b_gap", (starts_a.size() > k) ? starts_a[k] - starts_a[k-1] : -1, FRAME * CPB_A);

        // Reset 3000 cycles into a 0x55 frame with two more bytes queued.
        starts_a.delete();
        base_done = done_a;
        for (int i = 0; i < 3; i++) begin
            rb = (i == 0) ? 8'h55 : ((i == 1) ? 8'h11 : 8'h22);
            a_data = rb; a_valid = 1'b1; exp_a.push_back(rb);
            step();
            if (i == 0) c0 = cyc;
        end
        a_valid = 1'b0;
        wait_until(c0 + 1 + 3000);
        rst = 1'b1;
        step();
        check("abort_serial", int'(a_serial), 1);
        check("abort_busy",   int'(a_busy),   0);
        check("abort_ready",  int'(a_ready),  1);
        exp_a.delete();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (a_serial !== 1'b1 || a_busy !== 1'b0) bad++;
        end
        check("abort_quiet_cycles", bad, 0);
        check("abort_starts", starts_a.size(), 1);
        check("abort_monitor", aborts_a, 1);
        check("abort_no_frames", done_a - base_done, 0);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x93 carries parity 0, 0x01 carries parity 1.
        starts_a.delete();
        base_done = done_a;
        a_data = 8'h93; a_valid = 1'b1; exp_a.push_back(8'h93);
        step();
        c0 = cyc;
        a_data = 8'h01; exp_a.push_back(8'h01);
        step();
        a_valid = 1'b0;
        wait_until(c0 + 1 + 2 * FRAME * CPB_A);
        check("parity_frames", done_a - base_done, 2);
        check("parity_frame_len", (starts_a.size() > 1) ? starts_a[1] - starts_a[0] : -1, 9548);
        check("parity_busy_done", int'(a_busy), 0);
`endif

        // Fast instance: ten random bytes with random valid gaps.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 5)) begin
                b_data = 8'($urandom_range(0, 255));
                step();
            end
            rb = 8'($urandom_range(0, 255));
            b_data = rb; b_valid = 1'b1;
            waited = 0;
            while (!b_ready && waited < 200) begin
                step();
                waited++;
            end
            check("b_ready_wait", int'(waited < 200), 1);
            exp_b.push_back(rb);
            step();
            b_valid = 1'b0;
            b_data  = 8'($urandom_range(0, 255));
        end
        waited = 0;
        while (b_busy && waited < 2000) begin
            step();
            waited++;
        end
        step();
        check("b_drain", int'(b_busy), 0);
        check("b_frames", done_b, 10);
        check("b_scoreboard_empty", exp_b.size(), 0);
        check("a_scoreboard_empty", exp_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
